// File: rtl/cond_logic_if.sv
// Signal bundle between the instruction decoder and the conditional-execution
// stage: raw requests and ALU flags in, gated strobes and flag state out.
interface cond_logic_if;
  logic       En;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  // Decoder side: drives requests, observes gated strobes.
  modport master (
    output En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  // Conditional-execution stage side.
  modport slave (
    input  En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field
// against the registered flags and gates the decoder's write/branch requests.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET  = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input logic         clk,
  input logic         reset,
  cond_logic_if.slave bus
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       cond_ex;
  logic       gate;

  // Condition-field evaluation against {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = ~(n ^ v);
      4'b1011: r = n ^ v;
      4'b1100: r = ~z & ~(n ^ v);
      4'b1101: r = z | (n ^ v);
      4'b1110: r = 1'b1;
      default: r = NV_EXECUTES;
    endcase
    return r;
  endfunction

  // Condition uses only registered flags, so a flag-setting instruction
  // is judged by the flags that existed before it.
  always_comb begin
    cond_ex = cond_eval(bus.Cond, flags_q);
  end

  assign gate = bus.En & cond_ex & ~reset;

  // Next flags: partial update per FlagW half, only for executing instructions.
  always_comb begin
    flags_d = flags_q;
    if (bus.En && cond_ex) begin
      if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  // Flags register; reset discards any update requested in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) flags_q <= FLAG_RESET;
    else       flags_q <= flags_d;
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS  & gate;
  assign bus.RegWrite = bus.RegW & gate & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & gate;
  assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: two instances (default parameters, and a nonzero
// reset value with NV executing) driven by identical stimulus.
module tb_cond_logic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, pcs, regw, memw, nw;
  logic [3:0] cond, alu;
  logic [1:0] fw;

  cond_logic_if if0 ();
  cond_logic_if if1 ();

  assign if0.En = en;   assign if1.En = en;
  assign if0.Cond = cond; assign if1.Cond = cond;
  assign if0.ALUFlags = alu; assign if1.ALUFlags = alu;
  assign if0.FlagW = fw; assign if1.FlagW = fw;
  assign if0.PCS = pcs; assign if1.PCS = pcs;
  assign if0.RegW = regw; assign if1.RegW = regw;
  assign if0.MemW = memw; assign if1.MemW = memw;
  assign if0.NoWrite = nw; assign if1.NoWrite = nw;

  cond_logic #(.FLAG_RESET(4'b0000), .NV_EXECUTES(1'b0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
  cond_logic #(.FLAG_RESET(4'b1010), .NV_EXECUTES(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(if1));

  logic       o_cex [2];
  logic       o_pcsrc [2];
  logic       o_regw [2];
  logic       o_memw [2];
  logic [3:0] o_flags [2];
  assign o_cex[0] = if0.CondEx;     assign o_cex[1] = if1.CondEx;
  assign o_pcsrc[0] = if0.PCSrc;    assign o_pcsrc[1] = if1.PCSrc;
  assign o_regw[0] = if0.RegWrite;  assign o_regw[1] = if1.RegWrite;
  assign o_memw[0] = if0.MemWrite;  assign o_memw[1] = if1.MemWrite;
  assign o_flags[0] = if0.Flags;    assign o_flags[1] = if1.Flags;

  localparam logic [3:0] RST_VAL [2] = '{4'b0000, 4'b1010};
  localparam bit         NV_VAL  [2] = '{1'b0, 1'b1};

  typedef struct {
    logic       rst, en;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       pcs, regw, memw, nw;
    logic       chk;
    logic       e_cex, e_pcsrc, e_regw, e_memw;
    logic [3:0] e_flags;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] mf [2];

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference condition: ARM pairs each base test with its inverse via Cond[0].
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f, input bit nv);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return nv;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return c[0] ? !base : base;
  endfunction

  // One clock of stimulus: model checks on both instances, plus optional
  // hand-derived expectations on instance 0.
  task automatic cycle(input vec_t v);
    logic [3:0] nf [2];
    logic       ec, g;
    rst = v.rst; en = v.en; cond = v.cond; alu = v.alu; fw = v.fw;
    pcs = v.pcs; regw = v.regw; memw = v.memw; nw = v.nw;
    #2;
    for (int d = 0; d < 2; d++) begin
      ec = ref_cond(v.cond, mf[d], NV_VAL[d]);
      g  = v.en & ec & ~v.rst;
      check($sformatf("d%0d CondEx c=%h f=%b", d, v.cond, mf[d]), {3'b0, o_cex[d]}, {3'b0, ec});
      check($sformatf("d%0d PCSrc", d), {3'b0, o_pcsrc[d]}, {3'b0, v.pcs & g});
      check($sformatf("d%0d RegWrite", d), {3'b0, o_regw[d]}, {3'b0, v.regw & g & ~v.nw});
      check($sformatf("d%0d MemWrite", d), {3'b0, o_memw[d]}, {3'b0, v.memw & g});
      if (v.rst) nf[d] = RST_VAL[d];
      else if (v.en && ec)
        nf[d] = {v.fw[1] ? v.alu[3:2] : mf[d][3:2], v.fw[0] ? v.alu[1:0] : mf[d][1:0]};
      else nf[d] = mf[d];
    end
    if (v.chk) begin
      check("tbl CondEx",   {3'b0, o_cex[0]},   {3'b0, v.e_cex});
      check("tbl PCSrc",    {3'b0, o_pcsrc[0]}, {3'b0, v.e_pcsrc});
      check("tbl RegWrite", {3'b0, o_regw[0]},  {3'b0, v.e_regw});
      check("tbl MemWrite", {3'b0, o_memw[0]},  {3'b0, v.e_memw});
    end
    @(posedge clk);
    #1;
    mf[0] = nf[0];
    mf[1] = nf[1];
    for (int d = 0; d < 2; d++) check($sformatf("d%0d Flags", d), o_flags[d], mf[d]);
    if (v.chk) check("tbl Flags", o_flags[0], v.e_flags);
  endtask

  vec_t tbl [18];
  vec_t rv;

  initial begin
    // rst en cond alu fw pcs regw memw nw | chk cex pcsrc regw memw flags_next
    tbl[0]  = '{1,1,4'hE,4'b0000,2'b00,1,1,1,0, 1,1,0,0,0,4'b0000}; // reset
    tbl[1]  = '{0,1,4'hE,4'b0100,2'b11,0,1,0,0, 1,1,0,1,0,4'b0100}; // AL set Z
    tbl[2]  = '{0,1,4'h0,4'b0000,2'b00,0,0,1,0, 1,1,0,0,1,4'b0100}; // EQ store
    tbl[3]  = '{0,1,4'h1,4'b1000,2'b11,0,0,1,0, 1,0,0,0,0,4'b0100}; // NE fails
    tbl[4]  = '{0,1,4'hE,4'b0000,2'b11,0,0,0,0, 1,1,0,0,0,4'b0000};
    tbl[5]  = '{0,1,4'hE,4'b1111,2'b10,0,0,0,0, 1,1,0,0,0,4'b1100}; // NZ only
    tbl[6]  = '{0,1,4'hE,4'b0010,2'b01,0,0,0,0, 1,1,0,0,0,4'b1110}; // CV only
    tbl[7]  = '{0,1,4'hE,4'b0110,2'b11,0,1,0,1, 1,1,0,0,0,4'b0110}; // CMP
    tbl[8]  = '{0,0,4'hE,4'b1001,2'b11,1,1,1,0, 1,1,0,0,0,4'b0110}; // stall
    tbl[9]  = '{0,0,4'hE,4'b1001,2'b11,1,1,1,0, 1,1,0,0,0,4'b0110};
    tbl[10] = '{0,0,4'hE,4'b1001,2'b11,1,1,1,0, 1,1,0,0,0,4'b0110};
    tbl[11] = '{0,1,4'hE,4'b1001,2'b11,0,0,0,0, 1,1,0,0,0,4'b1001};
    tbl[12] = '{1,1,4'hE,4'b0100,2'b11,1,0,0,0, 1,1,0,0,0,4'b0000}; // reset wins
    tbl[13] = '{0,1,4'h0,4'b0100,2'b11,0,1,0,0, 1,0,0,0,0,4'b0000}; // EQ fails, no update
    tbl[14] = '{0,1,4'hE,4'b0100,2'b11,0,0,0,0, 1,1,0,0,0,4'b0100};
    tbl[15] = '{0,1,4'h0,4'b0000,2'b11,0,1,0,0, 1,1,0,1,0,4'b0000}; // ADDSEQ old Z
    tbl[16] = '{0,1,4'hF,4'b0000,2'b00,1,1,1,0, 1,0,0,0,0,4'b0000}; // NV off
    tbl[17] = '{0,1,4'hE,4'b0000,2'b00,1,1,1,0, 1,1,1,1,1,4'b0000}; // AL all strobes

    rst = 1'b1; en = 1'b0; cond = 4'h0; alu = 4'h0; fw = 2'b00;
    pcs = 1'b0; regw = 1'b0; memw = 1'b0; nw = 1'b0;
    @(posedge clk);
    #1;
    mf[0] = RST_VAL[0];
    mf[1] = RST_VAL[1];
    check("reset Flags d0", o_flags[0], 4'b0000);
    check("reset Flags d1", o_flags[1], 4'b1010);

    for (int i = 0; i < 18; i++) cycle(tbl[i]);

    // Full condition sweep: load each flag value, then try every condition.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        rv = '{0,1,4'hE,f[3:0],2'b11,0,0,0,0, 0,0,0,0,0,4'b0};
        cycle(rv);
        rv = '{0,1,c[3:0],4'b0000,2'b00,1,1,1,0, 0,0,0,0,0,4'b0};
        cycle(rv);
      end
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rv.rst  = ($urandom_range(0, 15) == 0);
      rv.en   = ($urandom_range(0, 3) != 0);
      rv.cond = 4'($urandom);
      rv.alu  = 4'($urandom);
      rv.fw   = 2'($urandom);
      rv.pcs  = 1'($urandom);
      rv.regw = 1'($urandom);
      rv.memw = 1'($urandom);
      rv.nw   = 1'($urandom);
      rv.chk  = 1'b0;
      rv.e_cex = 1'b0; rv.e_pcsrc = 1'b0; rv.e_regw = 1'b0; rv.e_memw = 1'b0;
      rv.e_flags = 4'b0;
      cycle(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
